// File: rtl/press_pkg.sv
// Shared types and sizing helpers for the press classifier.
package press_pkg;

  typedef enum logic [2:0] {
    WAIT_REL  = 3'd0,
    IDLE      = 3'd1,
    PRESS1    = 3'd2,
    LONG_HELD = 3'd3,
    GAP       = 3'd4
  } state_t;

  // Gesture code, also usable downstream as a compact mux select.
  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SHORT  = 2'd1,
    LONG   = 2'd2,
    DOUBLE = 2'd3
  } gesture_t;

  // One spare bit so the terminal count never aliases to zero.
  function automatic int unsigned timer_width(input int unsigned long_cycles,
                                              input int unsigned gap_cycles);
    int unsigned m;
    m = (long_cycles > gap_cycles) ? long_cycles : gap_cycles;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gesture_timer.sv
// Up-counter shared by the press and gap phases; done flags the terminal count.
module gesture_timer #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] limit,
  output logic         done
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (en) begin
      count <= count + W'(1);
    end
  end

  assign done = (count == limit);

endmodule

// File: rtl/press_classifier.sv
// Classifies debounced button presses into short, long and double gestures.
module press_classifier
  import press_pkg::*;
#(
  parameter int unsigned LONG_CYCLES = 50000000,
  parameter int unsigned GAP_CYCLES  = 12500000,
  parameter int unsigned CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s,
  output logic             short_press,
  output logic             long_press,
  output logic             double_press,
  output logic             hold,
  output logic [CNT_W-1:0] event_count
);

  localparam int unsigned TW = timer_width(LONG_CYCLES, GAP_CYCLES);
  localparam logic [TW-1:0] LONG_LIM = TW'(LONG_CYCLES - 1);
  localparam logic [TW-1:0] GAP_LIM  = TW'(GAP_CYCLES - 1);

  state_t        state;
  gesture_t      gesture;
  logic          timer_clr;
  logic          timer_en;
  logic          timer_done;
  logic [TW-1:0] timer_limit;

  // The timer only runs while the current phase is still waiting for its terminal count.
  always_comb begin
    timer_limit = (state == GAP) ? GAP_LIM : LONG_LIM;
    timer_en    = ((state == PRESS1) && s && !timer_done) ||
                  ((state == GAP) && !s && !timer_done);
    timer_clr   = !timer_en;
  end

  // s=1 in GAP wins over the gap expiring on the same cycle.
  always_comb begin
    gesture = NONE;
    case (state)
      PRESS1:  if (s && timer_done) gesture = LONG;
      GAP: begin
        if (s)               gesture = DOUBLE;
        else if (timer_done) gesture = SHORT;
      end
      default: gesture = NONE;
    endcase
  end

  gesture_timer #(.W(TW)) u_timer (
    .clk   (clk),
    .rst   (rst),
    .clr   (timer_clr),
    .en    (timer_en),
    .limit (timer_limit),
    .done  (timer_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= WAIT_REL;
      short_press  <= 1'b0;
      long_press   <= 1'b0;
      double_press <= 1'b0;
      hold         <= 1'b0;
      event_count  <= '0;
    end else begin
      short_press  <= (gesture == SHORT);
      long_press   <= (gesture == LONG);
      double_press <= (gesture == DOUBLE);
      if (gesture != NONE) begin
        event_count <= event_count + CNT_W'(1);
      end

      case (state)
        WAIT_REL: if (!s) state <= IDLE;
        IDLE:     if (s) state <= PRESS1;
        PRESS1: begin
          if (!s) begin
            state <= GAP;
          end else if (timer_done) begin
            hold  <= 1'b1;
            state <= LONG_HELD;
          end
        end
        LONG_HELD: begin
          if (!s) begin
            hold  <= 1'b0;
            state <= IDLE;
          end
        end
        GAP: begin
          if (s) begin
            state <= WAIT_REL;
          end else if (timer_done) begin
            state <= IDLE;
          end
        end
        default: state <= WAIT_REL;
      endcase
    end
  end

endmodule

// File: tb/tb_press_classifier.sv
// Directed per-cycle vectors for press_classifier with LONG=8, GAP=4, CNT_W=3.
module tb_press_classifier;

  logic       clk = 1'b0;
  logic       rst;
  logic       s;
  logic       short_press;
  logic       long_press;
  logic       double_press;
  logic       hold;
  logic [2:0] event_count;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       rst;
    logic       s;
    logic       sp;
    logic       lp;
    logic       dp;
    logic       hold;
    logic [2:0] cnt;
  } vec_t;

  vec_t vq[$];

  press_classifier #(
    .LONG_CYCLES (8),
    .GAP_CYCLES  (4),
    .CNT_W       (3)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .s            (s),
    .short_press  (short_press),
    .long_press   (long_press),
    .double_press (double_press),
    .hold         (hold),
    .event_count  (event_count)
  );

  always #5 clk = ~clk;

  task automatic push(input logic r, input logic sv, input logic sp, input logic lp,
                      input logic dp, input logic h, input logic [2:0] c, input int n);
    vec_t v;
    v.rst = r; v.s = sv; v.sp = sp; v.lp = lp; v.dp = dp; v.hold = h; v.cnt = c;
    for (int i = 0; i < n; i++) vq.push_back(v);
  endtask

  task automatic tick(input logic r, input logic sv);
    rst = r;
    s   = sv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [6:0] got, input logic [6:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got sp/lp/dp/hold/cnt=%b required=%b", name, got, exp);
    end
  endtask

  function automatic logic [6:0] outs();
    return {short_press, long_press, double_press, hold, event_count};
  endfunction

  int pulses;

  initial begin
    rst = 1'b1;
    s   = 1'b1;

    // Reset with s held, then held through release: never classified
    push(1, 1, 0, 0, 0, 0, 3'd0, 2);
    push(0, 1, 0, 0, 0, 0, 3'd0, 20);
    push(0, 0, 0, 0, 0, 0, 3'd0, 2);
    // Short press: 3 high, short on 5th low sample
    push(0, 1, 0, 0, 0, 0, 3'd0, 3);
    push(0, 0, 0, 0, 0, 0, 3'd0, 4);
    push(0, 0, 1, 0, 0, 0, 3'd1, 1);
    push(0, 0, 0, 0, 0, 0, 3'd1, 5);
    // Long press: pulse after 9th high sample, hold until release
    push(0, 1, 0, 0, 0, 0, 3'd1, 8);
    push(0, 1, 0, 1, 0, 1, 3'd2, 1);
    push(0, 1, 0, 0, 0, 1, 3'd2, 6);
    push(0, 0, 0, 0, 0, 0, 3'd2, 2);
    // Double press
    push(0, 1, 0, 0, 0, 0, 3'd2, 2);
    push(0, 0, 0, 0, 0, 0, 3'd2, 2);
    push(0, 1, 0, 0, 1, 0, 3'd3, 1);
    push(0, 1, 0, 0, 0, 0, 3'd3, 1);
    push(0, 0, 0, 0, 0, 0, 3'd3, 2);
    // Gap expires exactly, next press starts fresh from IDLE
    push(0, 1, 0, 0, 0, 0, 3'd3, 1);
    push(0, 0, 0, 0, 0, 0, 3'd3, 4);
    push(0, 0, 1, 0, 0, 0, 3'd4, 1);
    push(0, 1, 0, 0, 0, 0, 3'd4, 1);
    push(0, 0, 0, 0, 0, 0, 3'd4, 1);
    push(0, 1, 0, 0, 1, 0, 3'd5, 1);
    push(0, 0, 0, 0, 0, 0, 3'd5, 1);
    // Second press on the terminal gap cycle is a double, not a short
    push(0, 1, 0, 0, 0, 0, 3'd5, 1);
    push(0, 0, 0, 0, 0, 0, 3'd5, 4);
    push(0, 1, 0, 0, 1, 0, 3'd6, 1);
    push(0, 0, 0, 0, 0, 0, 3'd6, 2);
    // One cycle short of long is a short press; then long wraps the counter
    push(0, 1, 0, 0, 0, 0, 3'd6, 8);
    push(0, 0, 0, 0, 0, 0, 3'd6, 4);
    push(0, 0, 1, 0, 0, 0, 3'd7, 1);
    push(0, 1, 0, 0, 0, 0, 3'd7, 8);
    push(0, 1, 0, 1, 0, 1, 3'd0, 1);
    push(0, 0, 0, 0, 0, 0, 3'd0, 2);

    foreach (vq[i]) begin
      tick(vq[i].rst, vq[i].s);
      check($sformatf("vec%0d", i), outs(),
            {vq[i].sp, vq[i].lp, vq[i].dp, vq[i].hold, vq[i].cnt});
    end

    // Nine short presses from count 0 wrap to 1
    tick(1, 0);
    check("reset_clear", outs(), 7'b0);
    tick(0, 0);
    for (int p = 0; p < 9; p++) begin
      pulses = 0;
      tick(0, 1);
      tick(0, 1);
      for (int c = 0; c < 5; c++) begin
        tick(0, 0);
        if (short_press) pulses++;
        if (long_press || double_press || hold) pulses += 100;
      end
      total++;
      if (pulses != 1 || short_press !== 1'b1) begin
        bad++;
        $display("FAIL wrap_press%0d: got pulses=%0d last_sp=%b required pulses=1 last_sp=1",
                 p, pulses, short_press);
      end
    end
    tick(0, 0);
    check("wrap_count", outs(), {4'b0, 3'd1});

    // Reset mid-press discards the gesture and blocks classification while held
    tick(0, 1);
    tick(0, 1);
    tick(0, 1);
    tick(1, 1);
    check("mid_reset", outs(), 7'b0);
    pulses = 0;
    for (int c = 0; c < 12; c++) begin
      tick(0, 1);
      if (outs() != 7'b0) pulses++;
    end
    total++;
    if (pulses != 0) begin
      bad++;
      $display("FAIL held_after_reset: got nonzero_cycles=%0d required 0", pulses);
    end
    tick(0, 0);
    check("release_after_reset", outs(), 7'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
